regfile_mp: RTL and testbench

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/regfile_mp.sv | 122 ++++++++++++
 tb/tb_regfile_mp.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// Multi-port register file: 2 write ports, NRD combinational read ports with write bypass,
// bulk-clear FSM, and an optional pending-bit scoreboard enabled by REGFILE_SCOREBOARD_EN.
module regfile_mp #(
  parameter int  XLEN = 32,
  parameter int  NREG = 32,
  parameter int  NRD  = 2,
  localparam int AW   = $clog2(NREG)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr_req,
  output logic                 clr_busy,
  input  logic                 we0,
  input  logic [AW-1:0]        waddr0,
  input  logic [XLEN-1:0]      wdata0,
  input  logic                 we1,
  input  logic [AW-1:0]        waddr1,
  input  logic [XLEN-1:0]      wdata1,
  input  logic [NRD-1:0]       re,
  input  logic [NRD*AW-1:0]    raddr,
  output logic [NRD*XLEN-1:0]  rdata,
  input  logic                 iss_v,
  input  logic [AW-1:0]        iss_addr,
  output logic [NRD-1:0]       rvalid
);

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_e;

  state_e          state_q;
  logic [AW-1:0]   cnt_q;
  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic            wr0_act, wr1_act, rd_open;

  // A write is "active" only when it will really commit; bypass uses the same qualifier.
  assign wr0_act  = we0 && (waddr0 != '0) && (state_q == IDLE);
  assign wr1_act  = we1 && (waddr1 != '0) && (state_q == IDLE);
  assign rd_open  = !rst && (state_q == IDLE);
  assign clr_busy = (state_q == CLEAR);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (clr_req) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
          end
        end
        CLEAR: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == AW'(NREG - 1)) state_q <= IDLE;
        end
        default: state_q <= CLEAR;
      endcase
    end
  end

  // Port 1 is applied last so it wins an address collision with port 0.
  always_comb begin
    regs_d = regs_q;
    if (!rst) begin
      if (state_q == CLEAR) begin
        regs_d[cnt_q] = '0;
      end else begin
        if (wr0_act) regs_d[waddr0] = wdata0;
        if (wr1_act) regs_d[waddr1] = wdata1;
      end
    end
  end

  always_ff @(posedge clk) begin
    regs_q <= regs_d;
  end

`ifdef REGFILE_SCOREBOARD_EN
  logic [NREG-1:0] pend_q, pend_d;

  // Issue is applied after the write clears so a same-address set wins.
  always_comb begin
    pend_d = pend_q;
    if (state_q == CLEAR) begin
      pend_d = '0;
    end else begin
      if (wr0_act) pend_d[waddr0] = 1'b0;
      if (wr1_act) pend_d[waddr1] = 1'b0;
      if (iss_v && (iss_addr != '0)) pend_d[iss_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) pend_q <= '0;
    else     pend_q <= pend_d;
  end
`else
  logic unused_iss;
  assign unused_iss = iss_v ^ (^iss_addr);
`endif

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]   a;
    logic            hit0, hit1;
    logic [XLEN-1:0] rd;

    assign a    = raddr[k*AW +: AW];
    assign hit1 = wr1_act && (waddr1 == a);
    assign hit0 = wr0_act && (waddr0 == a);
    assign rd   = (!rd_open || !re[k] || (a == '0)) ? '0 :
                  hit1 ? wdata1 :
                  hit0 ? wdata0 : regs_q[a];
    assign rdata[k*XLEN +: XLEN] = rd;
`ifdef REGFILE_SCOREBOARD_EN
    assign rvalid[k] = rd_open && re[k] && ((a == '0) || !pend_q[a] || hit0 || hit1);
`else
    assign rvalid[k] = rd_open && re[k];
`endif
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed vector table, multi-cycle clear/reset
// sequences and randomized traffic against an array-based reference model.
module tb_regfile_mp;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NRD  = 2;
  localparam int AW   = 5;

  logic                clk = 1'b0;
  logic                rst, clr_req, clr_busy;
  logic                we0, we1, iss_v;
  logic [AW-1:0]       waddr0, waddr1, iss_addr;
  logic [XLEN-1:0]     wdata0, wdata1;
  logic [NRD-1:0]      re, rvalid;
  logic [NRD*AW-1:0]   raddr;
  logic [NRD*XLEN-1:0] rdata;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) dut (
    .clk(clk), .rst(rst), .clr_req(clr_req), .clr_busy(clr_busy),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .re(re), .raddr(raddr), .rdata(rdata),
    .iss_v(iss_v), .iss_addr(iss_addr), .rvalid(rvalid)
  );

  // Reference model: register contents, pending bits, and cycles of clearing still owed.
  logic [XLEN-1:0] m_regs [NREG];
  logic [NREG-1:0] m_pend;
  int              m_clear_left;

  function automatic logic [AW-1:0] rd_addr(int k);
    return raddr[k*AW +: AW];
  endfunction

  function automatic logic [XLEN-1:0] exp_rdata(int k);
    logic [AW-1:0] a;
    a = rd_addr(k);
    if (rst || (m_clear_left > 0) || !re[k] || (a == 0)) return '0;
    if (we1 && (waddr1 == a)) return wdata1;
    if (we0 && (waddr0 == a)) return wdata0;
    return m_regs[a];
  endfunction

  function automatic logic exp_rvalid(int k);
    logic [AW-1:0] a;
    a = rd_addr(k);
    if (rst || (m_clear_left > 0) || !re[k]) return 1'b0;
`ifdef REGFILE_SCOREBOARD_EN
    return (a == 0) || !m_pend[a] || (we1 && (waddr1 == a)) || (we0 && (waddr0 == a));
`else
    return 1'b1;
`endif
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check("clr_busy", 64'(clr_busy), 64'(m_clear_left > 0));
    for (int k = 0; k < NRD; k++) begin
      check($sformatf("rdata[%0d]", k), 64'(rdata[k*XLEN +: XLEN]), 64'(exp_rdata(k)));
      check($sformatf("rvalid[%0d]", k), 64'(rvalid[k]), 64'(exp_rvalid(k)));
    end
  endtask

  task automatic model_edge();
    if (rst) begin
      m_clear_left = NREG;
      m_pend       = '0;
    end else if (m_clear_left > 0) begin
      m_regs[NREG - m_clear_left] = '0;
      m_clear_left--;
      m_pend = '0;
    end else begin
      if (we0 && (waddr0 != 0)) begin m_regs[waddr0] = wdata0; m_pend[waddr0] = 1'b0; end
      if (we1 && (waddr1 != 0)) begin m_regs[waddr1] = wdata1; m_pend[waddr1] = 1'b0; end
      if (iss_v && (iss_addr != 0)) m_pend[iss_addr] = 1'b1;
      if (clr_req) m_clear_left = NREG;
    end
  endtask

  // Entered 1 time unit after a rising edge: check settled outputs, then advance one edge.
  task automatic step();
    #2;
    check_outputs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    clr_req = 1'b0; we0 = 1'b0; we1 = 1'b0;
    waddr0 = '0; waddr1 = '0; wdata0 = '0; wdata1 = '0;
    re = '0; raddr = '0; iss_v = 1'b0; iss_addr = '0;
  endtask

  task automatic drain_busy(input string name);
    int n;
    n = 0;
    idle();
    while ((clr_busy === 1'b1) && (n < 100)) begin
      step();
      n++;
    end
    check(name, 64'(n), 64'(NREG));
  endtask

  task automatic read_all();
    for (int a = 0; a < NREG; a += 2) begin
      idle();
      re    = 2'b11;
      raddr = {AW'(a + 1), AW'(a)};
      step();
    end
  endtask

  typedef struct {
    logic            we0; logic [AW-1:0] a0; logic [XLEN-1:0] d0;
    logic            we1; logic [AW-1:0] a1; logic [XLEN-1:0] d1;
    logic [NRD-1:0]  re;  logic [AW-1:0] r0; logic [AW-1:0]   r1;
    logic [XLEN-1:0] e0;  logic [XLEN-1:0] e1;
  } vec_t;

  vec_t vt [10];

  initial begin
    int n;
    for (int i = 0; i < NREG; i++) m_regs[i] = '0;
    m_pend       = '0;
    m_clear_left = 0;

    vt[0] = '{1'b1, 5'd5,  32'h11,        1'b1, 5'd5,  32'h22,        2'b11, 5'd5,  5'd0,  32'h22,        32'h0};
    vt[1] = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,         2'b11, 5'd5,  5'd5,  32'h22,        32'h22};
    vt[2] = '{1'b1, 5'd7,  32'hDEADBEEF,  1'b0, 5'd0,  32'h0,         2'b11, 5'd7,  5'd0,  32'hDEADBEEF,  32'h0};
    vt[3] = '{1'b1, 5'd0,  32'hFFFFFFFF,  1'b1, 5'd0,  32'h1234,      2'b11, 5'd0,  5'd7,  32'h0,         32'hDEADBEEF};
    vt[4] = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,         2'b01, 5'd5,  5'd7,  32'h22,        32'h0};
    vt[5] = '{1'b1, 5'd3,  32'hA,         1'b1, 5'd4,  32'hB,         2'b11, 5'd3,  5'd4,  32'hA,         32'hB};
    vt[6] = '{1'b1, 5'd4,  32'hC,         1'b1, 5'd3,  32'hD,         2'b11, 5'd3,  5'd4,  32'hD,         32'hC};
    vt[7] = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,         2'b11, 5'd3,  5'd4,  32'hD,         32'hC};
    vt[8] = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd31, 32'h80000001,  2'b11, 5'd31, 5'd30, 32'h80000001,  32'h0};
    vt[9] = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,         2'b11, 5'd0,  5'd31, 32'h0,         32'h80000001};

    // Reset: first edge enters CLEAR, outputs quiet while rst is held.
    idle();
    rst = 1'b1;
    @(posedge clk);
    model_edge();
    #1;
    check("reset_busy", 64'(clr_busy), 64'd1);
    re    = 2'b11;
    raddr = {AW'(9), AW'(3)};
    step();
    rst = 1'b0;
    drain_busy("reset_clear_len");
    read_all();

    // Directed vectors: dual-write conflict, bypass, x0 handling, read enables.
    for (int i = 0; i < 10; i++) begin
      idle();
      we0 = vt[i].we0; waddr0 = vt[i].a0; wdata0 = vt[i].d0;
      we1 = vt[i].we1; waddr1 = vt[i].a1; wdata1 = vt[i].d1;
      re  = vt[i].re;  raddr  = {vt[i].r1, vt[i].r0};
      #2;
      check($sformatf("vec%0d_rd0", i), 64'(rdata[XLEN-1:0]), 64'(vt[i].e0));
      check($sformatf("vec%0d_rd1", i), 64'(rdata[2*XLEN-1:XLEN]), 64'(vt[i].e1));
      step();
    end

`ifdef REGFILE_SCOREBOARD_EN
    idle(); iss_v = 1'b1; iss_addr = 5'd9; step();
    idle(); re = 2'b01; raddr = {AW'(0), AW'(9)};
    #2; check("sb_pending_rvalid", 64'(rvalid[0]), 64'd0);
    step();
    we0 = 1'b1; waddr0 = 5'd9; wdata0 = 32'h5A;
    #2; check("sb_bypass_rvalid", 64'(rvalid[0]), 64'd1);
    check("sb_bypass_data", 64'(rdata[XLEN-1:0]), 64'h5A);
    step();
    idle(); re = 2'b01; raddr = {AW'(0), AW'(9)};
    #2; check("sb_after_rvalid", 64'(rvalid[0]), 64'd1);
    check("sb_after_data", 64'(rdata[XLEN-1:0]), 64'h5A);
    step();
`endif

    // Clear mid-operation: load index values, clear, ignore writes and clr_req during CLEAR.
    for (int a = 1; a < NREG; a++) begin
      idle(); we0 = 1'b1; waddr0 = AW'(a); wdata0 = XLEN'(a); step();
    end
    idle(); re = 2'b11; raddr = {AW'(30), AW'(3)};
    #2; check("load_r3", 64'(rdata[XLEN-1:0]), 64'd3);
    check("load_r30", 64'(rdata[2*XLEN-1:XLEN]), 64'd30);
    step();
    idle(); clr_req = 1'b1; step();
    n = 0;
    while ((clr_busy === 1'b1) && (n < 100)) begin
      idle();
      re    = 2'b11;
      raddr = {AW'($urandom_range(1, NREG-1)), AW'($urandom_range(1, NREG-1))};
      if (n == 5) clr_req = 1'b1;
      if (n == 20) begin we0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'h99; end
      #2; check("clear_rd0_zero", 64'(rdata[XLEN-1:0]), 64'd0);
      step();
      n++;
    end
    check("clear_len", 64'(n), 64'(NREG));
    idle(); re = 2'b11; raddr = {AW'(31), AW'(3)};
    #2; check("clear_r3_zero", 64'(rdata[XLEN-1:0]), 64'd0);
    check("clear_r31_zero", 64'(rdata[2*XLEN-1:XLEN]), 64'd0);
    step();
    read_all();

    // Reset mid-CLEAR at cnt=10 restarts the full sequence.
    idle(); we0 = 1'b1; waddr0 = 5'd15; wdata0 = 32'h15;
    we1 = 1'b1; waddr1 = 5'd25; wdata1 = 32'h25; step();
    idle(); clr_req = 1'b1; step();
    for (int i = 0; i < 10; i++) begin
      idle(); re = 2'b11; raddr = {AW'(25), AW'(15)}; step();
    end
    idle(); rst = 1'b1; re = 2'b11; raddr = {AW'(25), AW'(15)}; step();
    rst = 1'b0;
    drain_busy("rst_mid_clear_len");
    idle(); re = 2'b11; raddr = {AW'(25), AW'(15)};
    #2; check("rst_clear_r15", 64'(rdata[XLEN-1:0]), 64'd0);
    check("rst_clear_r25", 64'(rdata[2*XLEN-1:XLEN]), 64'd0);
    step();

    // Randomized traffic with collisions, occasional clears and resets.
    for (int c = 0; c < 1500; c++) begin
      rst     = ($urandom_range(0, 299) == 0);
      clr_req = ($urandom_range(0, 79) == 0);
      we0     = 1'($urandom_range(0, 1));
      we1     = 1'($urandom_range(0, 1));
      waddr0  = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 3)) : AW'($urandom_range(0, NREG-1));
      waddr1  = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 3)) : AW'($urandom_range(0, NREG-1));
      wdata0  = $urandom();
      wdata1  = $urandom();
      iss_v   = ($urandom_range(0, 2) == 0);
      iss_addr = ($urandom_range(0, 1) == 0) ? waddr0 : AW'($urandom_range(0, NREG-1));
      re      = NRD'($urandom_range(0, 3));
      for (int k = 0; k < NRD; k++) begin
        case ($urandom_range(0, 3))
          0:       raddr[k*AW +: AW] = waddr0;
          1:       raddr[k*AW +: AW] = waddr1;
          2:       raddr[k*AW +: AW] = iss_addr;
          default: raddr[k*AW +: AW] = AW'($urandom_range(0, NREG-1));
        endcase
      end
      step();
    end
    rst = 1'b0;
    idle();
    n = 0;
    while ((clr_busy === 1'b1) && (n < 100)) begin
      step();
      n++;
    end
    read_all();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
